// File: rtl/data_path_mc.sv
// data_path_mc: multi-cycle MIPS-style datapath. Accepts a decoded control
// bundle over valid/ready, then sequences EXEC -> (MEM) -> WB, with a
// wait-state tolerant data-memory handshake and parametrised width/regcount.
module data_path_mc #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREG     = 32,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic             MemtoReg,
  input  logic             Branch,
  input  logic             ALUSrc_B,
  input  logic             RegWrite,
  input  logic             RegDst,
  input  logic             Jump,
  input  logic             MemWrite,
  input  logic [2:0]       ALU_Control,
  input  logic [25:0]      inst_field,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] Data_in,
  output logic [WIDTH-1:0] ALU_out,
  output logic [WIDTH-1:0] Data_out,
  output logic [31:0]      PC_out,
  output logic             zero,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t state, next_state;

  // Latched control bundle and operands for the instruction in flight
  logic             mtr_r, br_r, asrc_r, rw_r, rdst_r, jmp_r, mw_r;
  logic [2:0]       alu_op_r;
  logic [25:0]      field_r;
  logic [WIDTH-1:0] a_r, b_r, mdr_r;
  logic [WIDTH-1:0] rf [NREG];

  logic             ready_d, req_d, we_d;
  logic [AW-1:0]    rs_idx, rt_idx, dbg_idx, wr_idx;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] imm_ext, op_b, alu_res, wr_data;
  logic             wr_en;
  logic [31:0]      p4, br_off, pc_next;

  // Register-file read ports; index 0 is hard-wired to zero
  assign rs_idx   = inst_field[21 +: AW];
  assign rt_idx   = inst_field[16 +: AW];
  assign dbg_idx  = dbg_addr[AW-1:0];
  assign rd_a     = (rs_idx  == '0) ? '0 : rf[rs_idx];
  assign rd_b     = (rt_idx  == '0) ? '0 : rf[rt_idx];
  assign dbg_data = (dbg_idx == '0) ? '0 : rf[dbg_idx];

  // Immediate sign extension for the ALU and the branch offset
  assign imm_ext = {{(WIDTH - 16){field_r[15]}}, field_r[15:0]};
  assign br_off  = {{14{field_r[15]}}, field_r[15:0], 2'b00};

  // ALU; unknown or unused op codes fall to zero so X never reaches state
  always_comb begin
    op_b    = asrc_r ? imm_ext : b_r;
    alu_res = '0;
    case (alu_op_r)
      3'b000:  alu_res = a_r & op_b;
      3'b001:  alu_res = a_r | op_b;
      3'b010:  alu_res = a_r + op_b;
      3'b011:  alu_res = a_r ^ op_b;
      3'b100:  alu_res = ~(a_r | op_b);
      3'b101:  alu_res = a_r >> op_b[4:0];
      3'b110:  alu_res = a_r - op_b;
      3'b111:  alu_res = WIDTH'($signed(a_r) < $signed(op_b));
      default: alu_res = '0;
    endcase
  end

  // Write-back target and PC successor; Jump wins over Branch
  always_comb begin
    wr_idx  = rdst_r ? field_r[11 +: AW] : field_r[16 +: AW];
    wr_en   = rw_r && (wr_idx != '0);
    wr_data = mtr_r ? mdr_r : ALU_out;
    p4      = PC_out + 32'd4;
    if (jmp_r)
      pc_next = {p4[31:28], field_r, 2'b00};
    else if (br_r && zero)
      pc_next = p4 + br_off;
    else
      pc_next = p4;
  end

  // Next-state and next-output decode
  always_comb begin
    next_state = state;
    ready_d    = 1'b0;
    req_d      = 1'b0;
    we_d       = 1'b0;
    case (state)
      IDLE: if (inst_valid) next_state = EXEC;
      EXEC: next_state = (mtr_r || mw_r) ? MEM : WB;
      MEM:  if (mem_ready) next_state = WB;
      WB:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    ready_d = (next_state == IDLE);
    req_d   = (next_state == MEM);
    we_d    = req_d && mw_r;
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      inst_ready <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      state      <= next_state;
      inst_ready <= ready_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
    end
  end

  // Datapath registers, register file and PC, advanced per phase
  always_ff @(posedge clk) begin
    if (rst) begin
      mtr_r    <= 1'b0;
      br_r     <= 1'b0;
      asrc_r   <= 1'b0;
      rw_r     <= 1'b0;
      rdst_r   <= 1'b0;
      jmp_r    <= 1'b0;
      mw_r     <= 1'b0;
      alu_op_r <= 3'b000;
      field_r  <= '0;
      a_r      <= '0;
      b_r      <= '0;
      mdr_r    <= '0;
      ALU_out  <= '0;
      Data_out <= '0;
      zero     <= 1'b0;
      PC_out   <= PC_RESET;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_valid) begin
            mtr_r    <= MemtoReg;
            br_r     <= Branch;
            asrc_r   <= ALUSrc_B;
            rw_r     <= RegWrite;
            rdst_r   <= RegDst;
            jmp_r    <= Jump;
            mw_r     <= MemWrite;
            alu_op_r <= ALU_Control;
            field_r  <= inst_field;
            a_r      <= rd_a;
            b_r      <= rd_b;
            Data_out <= rd_b;
          end
        end
        EXEC: begin
          ALU_out <= alu_res;
          zero    <= (alu_res == '0);
        end
        MEM: begin
          if (mem_ready && mtr_r) mdr_r <= Data_in;
        end
        WB: begin
          PC_out <= pc_next;
          if (wr_en) rf[wr_idx] <= wr_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_path_mc.sv
// tb_data_path_mc: directed bench for data_path_mc, 32-bit/32-reg instance
// plus a 64-bit/16-reg instance for width and index-aliasing behaviour.
module tb_data_path_mc;

  logic        clk, rst;
  logic        inst_valid0, inst_valid1;
  logic        MemtoReg, Branch, ALUSrc_B, RegWrite, RegDst, Jump, MemWrite;
  logic [2:0]  ALU_Control;
  logic [25:0] inst_field;
  logic        mem_ready;
  logic [4:0]  dbg_addr;

  logic        inst_ready0, mem_req0, mem_we0, zero0;
  logic [31:0] Data_in0, ALU_out0, Data_out0, PC_out0, dbg_data0;

  logic        inst_ready1, mem_req1, mem_we1, zero1;
  logic [63:0] Data_in1, ALU_out1, Data_out1, dbg_data1;
  logic [31:0] PC_out1;

  int          checks, failures;
  int          ncyc, nreq;
  logic [31:0] req_addr, req_data;
  logic        req_we;

  data_path_mc #(.WIDTH(32), .NREG(32), .PC_RESET(32'h0)) dut0 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid0), .inst_ready(inst_ready0),
    .MemtoReg(MemtoReg), .Branch(Branch), .ALUSrc_B(ALUSrc_B),
    .RegWrite(RegWrite), .RegDst(RegDst), .Jump(Jump), .MemWrite(MemWrite),
    .ALU_Control(ALU_Control), .inst_field(inst_field),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_ready(mem_ready),
    .Data_in(Data_in0), .ALU_out(ALU_out0), .Data_out(Data_out0),
    .PC_out(PC_out0), .zero(zero0), .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
  );

  data_path_mc #(.WIDTH(64), .NREG(16), .PC_RESET(32'h0)) dut1 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid1), .inst_ready(inst_ready1),
    .MemtoReg(MemtoReg), .Branch(Branch), .ALUSrc_B(ALUSrc_B),
    .RegWrite(RegWrite), .RegDst(RegDst), .Jump(Jump), .MemWrite(MemWrite),
    .ALU_Control(ALU_Control), .inst_field(inst_field),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_ready(mem_ready),
    .Data_in(Data_in1), .ALU_out(ALU_out1), .Data_out(Data_out1),
    .PC_out(PC_out1), .zero(zero1), .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read a dut0 register through the debug port and compare
  task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_addr = 5'(idx);
    #1;
    check(tag, 64'(dbg_data0), 64'(exp));
  endtask

  // Present one bundle at a negedge, then run it to completion, acting as
  // a memory that raises mem_ready after 'waits' request cycles
  task automatic issue(input bit sel, input logic mtr, br, asrc, rw, rdst, jmp, mw,
                       input logic [2:0] op, input logic [25:0] fld, input int waits);
    logic rdy;
    MemtoReg = mtr; Branch = br; ALUSrc_B = asrc; RegWrite = rw;
    RegDst = rdst; Jump = jmp; MemWrite = mw; ALU_Control = op; inst_field = fld;
    if (sel) inst_valid1 = 1'b1; else inst_valid0 = 1'b1;
    ncyc = 0; nreq = 0; req_addr = '0; req_data = '0; req_we = 1'b0;
    @(posedge clk);
    #1 inst_valid0 = 1'b0; inst_valid1 = 1'b0;
    do begin
      @(negedge clk);
      ncyc++;
      if (!sel && mem_req0) begin
        nreq++;
        req_addr = ALU_out0; req_data = Data_out0; req_we = mem_we0;
      end
      mem_ready = !sel && mem_req0 && (nreq == waits + 1);
      rdy = sel ? inst_ready1 : inst_ready0;
    end while (!rdy && ncyc < 40);
    mem_ready = 1'b0;
    check("instr_done", 64'(rdy), 64'h1);
  endtask

  task automatic rtype(input logic [2:0] op, input int rs, rt, rd);
    issue(1'b0, 0, 0, 0, 1, 1, 0, 0, op, {5'(rs), 5'(rt), 5'(rd), 11'd0}, 0);
  endtask

  task automatic itype(input bit sel, input int rs, rt, input logic [15:0] imm);
    issue(sel, 0, 0, 1, 1, 0, 0, 0, 3'b010, {5'(rs), 5'(rt), imm}, 0);
  endtask

  task automatic lw(input int rt, rs, input logic [15:0] imm, input logic [31:0] d, input int waits);
    Data_in0 = d;
    issue(1'b0, 1, 0, 1, 1, 0, 0, 0, 3'b010, {5'(rs), 5'(rt), imm}, waits);
  endtask

  task automatic beq(input int rs, rt, input logic [15:0] imm);
    issue(1'b0, 0, 1, 0, 0, 0, 0, 0, 3'b110, {5'(rs), 5'(rt), imm}, 0);
  endtask

  // Directed sequence
  initial begin
    logic [31:0] acc;
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b1; inst_valid0 = 1'b0; inst_valid1 = 1'b0;
    MemtoReg = 0; Branch = 0; ALUSrc_B = 0; RegWrite = 0; RegDst = 0;
    Jump = 0; MemWrite = 0; ALU_Control = 3'b000; inst_field = '0;
    mem_ready = 1'b0; dbg_addr = '0; Data_in0 = '0; Data_in1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ready",  64'(inst_ready0), 64'h1);
    check("rst_pc",     64'(PC_out0),     64'h0);
    check("rst_aluout", 64'(ALU_out0),    64'h0);
    check("rst_dout",   64'(Data_out0),   64'h0);
    check("rst_zero",   64'(zero0),       64'h0);
    check("rst_req",    64'({mem_req0, mem_we0}), 64'h0);
    chk_reg("rst_r5", 5, 32'h0);

    // lw r5,14(r0) with two wait cycles
    lw(5, 0, 16'd14, 32'h5555_5555, 2);
    check("lw_cycles",  64'(ncyc),     64'd6);
    check("lw_reqcyc",  64'(nreq),     64'd3);
    check("lw_addr",    64'(req_addr), 64'd14);
    check("lw_we",      64'(req_we),   64'h0);
    chk_reg("lw_r5", 5, 32'h5555_5555);
    check("lw_pc",      64'(PC_out0),  64'h4);

    // add r1,r5,r0 ; nor r2,r0,r1
    rtype(3'b010, 5, 0, 1);
    check("add_cycles", 64'(ncyc), 64'd3);
    chk_reg("add_r1", 1, 32'h5555_5555);
    check("add_pc", 64'(PC_out0), 64'h8);
    rtype(3'b100, 0, 1, 2);
    chk_reg("nor_r2", 2, 32'hAAAA_AAAA);
    check("nor_pc", 64'(PC_out0), 64'hC);

    // Taken branch: r5 = r2, PC = 0x14 - 20
    lw(5, 0, 16'd0, 32'hAAAA_AAAA, 0);
    check("lw0_cycles", 64'(ncyc), 64'd4);
    beq(2, 5, 16'hFFFB);
    check("beq_t_zero", 64'(zero0),   64'h1);
    check("beq_t_pc",   64'(PC_out0), 64'h0);

    // Not-taken branch: r5 != r2, PC = 8
    lw(5, 0, 16'd0, 32'h1234_5678, 1);
    check("lw1_cycles", 64'(ncyc), 64'd5);
    beq(2, 5, 16'hFFFB);
    check("beq_n_zero", 64'(zero0),   64'h0);
    check("beq_n_pc",   64'(PC_out0), 64'h8);

    // Jumps with unknown ALU_Control
    issue(1'b0, 0, 0, 0, 0, 0, 1, 0, 3'bxxx, 26'h0, 0);
    check("j0_pc", 64'(PC_out0), 64'h0);
    chk_reg("j0_r1", 1, 32'h5555_5555);
    chk_reg("j0_r2", 2, 32'hAAAA_AAAA);
    issue(1'b0, 0, 0, 0, 0, 0, 1, 0, 3'bxxx, 26'h10, 0);
    check("j1_pc", 64'(PC_out0), 64'h40);

    // Write to r0 is discarded
    rtype(3'b010, 1, 1, 0);
    check("addr0_alu", 64'(ALU_out0), 64'hAAAA_AAAA);
    chk_reg("addr0_r0", 0, 32'h0);

    // Signed compare and shift
    itype(1'b0, 0, 1, 16'hFFFF);
    chk_reg("addi_r1", 1, 32'hFFFF_FFFF);
    itype(1'b0, 0, 2, 16'h0001);
    rtype(3'b111, 1, 2, 3);
    chk_reg("slt_r3", 3, 32'h1);
    rtype(3'b111, 2, 1, 4);
    chk_reg("slt_r4", 4, 32'h0);
    check("slt_zero", 64'(zero0), 64'h1);
    lw(6, 0, 16'd0, 32'h8000_0000, 0);
    itype(1'b0, 0, 7, 16'h0004);
    rtype(3'b101, 6, 7, 8);
    chk_reg("srl_r8", 8, 32'h0800_0000);
    rtype(3'b011, 1, 5, 9);
    chk_reg("xor_r9", 9, 32'hEDCB_A987);
    rtype(3'b000, 5, 2, 10);
    chk_reg("and_r10", 10, 32'h0);
    check("and_zero", 64'(zero0), 64'h1);
    rtype(3'b001, 2, 7, 11);
    chk_reg("or_r11", 11, 32'h5);
    check("or_pc", 64'(PC_out0), 64'h6C);

    // sw r1,8(r0), reset while the memory stalls
    MemtoReg = 0; Branch = 0; ALUSrc_B = 1; RegWrite = 0; RegDst = 0;
    Jump = 0; MemWrite = 1; ALU_Control = 3'b010; inst_field = {5'd0, 5'd1, 16'd8};
    inst_valid0 = 1'b1;
    @(posedge clk);
    #1 inst_valid0 = 1'b0;
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (!mem_req0 && ncyc < 10);
    check("sw_req",  64'(mem_req0),  64'h1);
    check("sw_we",   64'(mem_we0),   64'h1);
    check("sw_addr", 64'(ALU_out0),  64'h8);
    check("sw_data", 64'(Data_out0), 64'hFFFF_FFFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_req",   64'(mem_req0),    64'h0);
    check("mrst_pc",    64'(PC_out0),     64'h0);
    check("mrst_ready", 64'(inst_ready0), 64'h1);
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 acc = acc | dbg_data0;
    end
    check("mrst_regs", 64'(acc), 64'h0);

    // 64-bit / 16-register instance: sext to 64 bits and modulo add
    itype(1'b1, 0, 1, 16'hFFFF);
    dbg_addr = 5'd1;
    #1 check("w64_r1", dbg_data1, 64'hFFFF_FFFF_FFFF_FFFF);
    itype(1'b1, 17, 18, 16'h0002);
    check("w64_alu",  ALU_out1,      64'h1);
    check("w64_zero", 64'(zero1),    64'h0);
    dbg_addr = 5'd18;
    #1 check("w64_r2", dbg_data1, 64'h1);
    check("w64_pc", 64'(PC_out1), 64'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
